// File: rtl/johnson_seq_decoder.sv
// Johnson-code receive checker: decodes to a phase index, validates code and step order, tracks lock and wraps.
// Latency: 1 cycle; every output is a register or a decode of the state register.
// Backpressure: none; code_valid low freezes all state and zeroes the pulse outputs.
module johnson_seq_decoder #(
    parameter int WIDTH      = 4,
    parameter int LOCK_COUNT = 3,
    parameter int WRAP_W     = 8,
    localparam int PW        = $clog2(2*WIDTH)
) (
    input  logic              Clk,
    input  logic              Clr,
    input  logic [WIDTH-1:0]  code_in,
    input  logic              code_valid,
    output logic [PW-1:0]     phase,
    output logic              phase_valid,
    output logic              locked,
    output logic              illegal_code,
    output logic              seq_error,
    output logic              wrap,
    output logic [WRAP_W-1:0] wrap_count
);

    typedef enum logic [1:0] {
        HUNT   = 2'd0,
        VERIFY = 2'd1,
        LOCKED = 2'd2
    } state_t;

    localparam logic [PW:0]   NST    = (PW+1)'(2*WIDTH);
    localparam logic [PW-1:0] LAST   = PW'(2*WIDTH-1);
    localparam logic [PW:0]   LOCK_N = (PW+1)'(LOCK_COUNT);

    state_t              state_q, state_d;
    logic [PW-1:0]       phase_q, phase_d;
    logic [PW:0]         cnt_q, cnt_d;
    logic [WRAP_W-1:0]   wc_q, wc_d;
    logic                ill_q, ill_d;
    logic                serr_q, serr_d;
    logic                wrap_q, wrap_d;

    logic                legal;
    logic                seen;
    logic                multi;
    logic [PW:0]         ones;
    logic [PW-1:0]       dec;
    logic [PW-1:0]       nxt;

    // A Johnson code has at most one 0/1 boundary between adjacent bits.
    // MSB set: index equals the number of ones; MSB clear: index is 2W minus the ones (all-zero is 0).
    always_comb begin
        seen  = 1'b0;
        multi = 1'b0;
        for (int i = 0; i < WIDTH-1; i++) begin
            if (code_in[i] != code_in[i+1]) begin
                if (seen) begin
                    multi = 1'b1;
                end
                seen = 1'b1;
            end
        end
        legal = !multi;

        ones = '0;
        for (int i = 0; i < WIDTH; i++) begin
            ones = ones + (PW+1)'(code_in[i]);
        end

        if (code_in[WIDTH-1]) begin
            dec = ones[PW-1:0];
        end else if (ones == '0) begin
            dec = '0;
        end else begin
            dec = PW'(NST - ones);
        end

        nxt = (phase_q == LAST) ? '0 : phase_q + PW'(1);
    end

    always_comb begin
        state_d = state_q;
        phase_d = phase_q;
        cnt_d   = cnt_q;
        wc_d    = wc_q;
        ill_d   = 1'b0;
        serr_d  = 1'b0;
        wrap_d  = 1'b0;
        if (code_valid) begin
            if (!legal) begin
                ill_d   = 1'b1;
                state_d = HUNT;
                cnt_d   = '0;
            end else begin
                case (state_q)
                    HUNT: begin
                        phase_d = dec;
                        cnt_d   = (PW+1)'(1);
                        state_d = VERIFY;
                    end
                    VERIFY: begin
                        if (dec == nxt) begin
                            phase_d = nxt;
                            cnt_d   = cnt_q + (PW+1)'(1);
                            if (cnt_q + (PW+1)'(1) == LOCK_N) begin
                                state_d = LOCKED;
                            end
                        end else if (dec != phase_q) begin
                            // Re-anchor silently; ordering is only enforced once locked.
                            phase_d = dec;
                            cnt_d   = (PW+1)'(1);
                        end
                    end
                    LOCKED: begin
                        if (dec == nxt) begin
                            phase_d = nxt;
                            if (phase_q == LAST) begin
                                wrap_d = 1'b1;
                                wc_d   = wc_q + WRAP_W'(1);
                            end
                        end else if (dec != phase_q) begin
                            serr_d  = 1'b1;
                            phase_d = dec;
                            cnt_d   = (PW+1)'(1);
                            state_d = VERIFY;
                        end
                    end
                    default: begin
                        state_d = HUNT;
                    end
                endcase
            end
        end
    end

    always_ff @(posedge Clk or negedge Clr) begin
        if (!Clr) begin
            state_q <= HUNT;
            phase_q <= '0;
            cnt_q   <= '0;
            wc_q    <= '0;
            ill_q   <= 1'b0;
            serr_q  <= 1'b0;
            wrap_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            phase_q <= phase_d;
            cnt_q   <= cnt_d;
            wc_q    <= wc_d;
            ill_q   <= ill_d;
            serr_q  <= serr_d;
            wrap_q  <= wrap_d;
        end
    end

    assign phase        = phase_q;
    assign phase_valid  = (state_q != HUNT);
    assign locked       = (state_q == LOCKED);
    assign illegal_code = ill_q;
    assign seq_error    = serr_q;
    assign wrap         = wrap_q;
    assign wrap_count   = wc_q;

endmodule

// File: tb/tb_johnson_seq_decoder.sv
// Scoreboard bench for johnson_seq_decoder: a table-driven reference model pushes expected outputs
// per driven sample; they are popped and compared one cycle later, plus directed reset checks.
module tb_johnson_seq_decoder;

    logic       Clk;
    logic       Clr;
    logic [3:0] code_in;
    logic       code_valid;
    logic [2:0] phase;
    logic       phase_valid;
    logic       locked;
    logic       illegal_code;
    logic       seq_error;
    logic       wrap;
    logic [7:0] wrap_count;

    johnson_seq_decoder #(.WIDTH(4), .LOCK_COUNT(3), .WRAP_W(8)) dut (
        .Clk          (Clk),
        .Clr          (Clr),
        .code_in      (code_in),
        .code_valid   (code_valid),
        .phase        (phase),
        .phase_valid  (phase_valid),
        .locked       (locked),
        .illegal_code (illegal_code),
        .seq_error    (seq_error),
        .wrap         (wrap),
        .wrap_count   (wrap_count)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    typedef struct packed {
        logic [2:0] ph;
        logic       pv;
        logic       lk;
        logic       ill;
        logic       se;
        logic       wr;
        logic [7:0] wc;
    } exp_t;

    exp_t sbq[$];
    int   total = 0;
    int   bad   = 0;

    // Reference model state: 0=HUNT 1=VERIFY 2=LOCKED
    int   m_st  = 0;
    int   m_ph  = 0;
    int   m_cnt = 0;
    int   m_wc  = 0;

    logic [3:0] jtab [8] = '{4'b0000, 4'b1000, 4'b1100, 4'b1110,
                             4'b1111, 4'b0111, 4'b0011, 4'b0001};

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic int jdec(input logic [3:0] c);
        int r;
        r = -1;
        for (int k = 0; k < 8; k++) begin
            if (jtab[k] == c) r = k;
        end
        return r;
    endfunction

    task automatic model_reset();
        m_st = 0; m_ph = 0; m_cnt = 0; m_wc = 0;
    endtask

    task automatic model_step(input logic [3:0] c, input logic v, output exp_t e);
        int d;
        int nx;
        e = '0;
        d  = jdec(c);
        nx = (m_ph + 1) % 8;
        if (v) begin
            if (d < 0) begin
                e.ill = 1'b1;
                m_st  = 0;
                m_cnt = 0;
            end else if (m_st == 0) begin
                m_ph = d; m_cnt = 1; m_st = 1;
            end else if (m_st == 1) begin
                if (d == nx) begin
                    m_ph = d; m_cnt++;
                    if (m_cnt == 3) m_st = 2;
                end else if (d != m_ph) begin
                    m_ph = d; m_cnt = 1;
                end
            end else begin
                if (d == nx) begin
                    if (m_ph == 7) begin
                        e.wr = 1'b1;
                        m_wc = (m_wc + 1) % 256;
                    end
                    m_ph = d;
                end else if (d != m_ph) begin
                    e.se = 1'b1; m_ph = d; m_cnt = 1; m_st = 1;
                end
            end
        end
        e.ph = 3'(m_ph);
        e.pv = (m_st != 0);
        e.lk = (m_st == 2);
        e.wc = 8'(m_wc);
    endtask

    task automatic drive(input logic [3:0] c, input logic v);
        exp_t e;
        exp_t x;
        @(negedge Clk);
        code_in    = c;
        code_valid = v;
        model_step(c, v, e);
        sbq.push_back(e);
        @(posedge Clk);
        #1;
        if (sbq.size() == 0) begin
            chk("sb_empty", 1, 0);
        end else begin
            x = sbq.pop_front();
            chk("phase",        32'(phase),        32'(x.ph));
            chk("phase_valid",  32'(phase_valid),  32'(x.pv));
            chk("locked",       32'(locked),       32'(x.lk));
            chk("illegal_code", 32'(illegal_code), 32'(x.ill));
            chk("seq_error",    32'(seq_error),    32'(x.se));
            chk("wrap",         32'(wrap),         32'(x.wr));
            chk("wrap_count",   32'(wrap_count),   32'(x.wc));
        end
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, "_phase"}, 32'(phase),        0);
        chk({tag, "_pv"},    32'(phase_valid),  0);
        chk({tag, "_lk"},    32'(locked),       0);
        chk({tag, "_ill"},   32'(illegal_code), 0);
        chk({tag, "_se"},    32'(seq_error),    0);
        chk({tag, "_wr"},    32'(wrap),         0);
        chk({tag, "_wc"},    32'(wrap_count),   0);
    endtask

    initial begin
        logic [3:0] rc;
        Clr        = 1'b0;
        code_in    = 4'b0000;
        code_valid = 1'b0;
        #3;
        chk_zero("rst");
        @(negedge Clk);
        Clr = 1'b1;

        // Acquire
        drive(4'b0000, 1'b1);
        drive(4'b1000, 1'b1);
        drive(4'b1100, 1'b1);
        chk("acq_locked", 32'(locked), 1);
        chk("acq_phase",  32'(phase),  2);

        // Two full wraps
        drive(4'b1110, 1'b1); drive(4'b1111, 1'b1); drive(4'b0111, 1'b1);
        drive(4'b0011, 1'b1); drive(4'b0001, 1'b1); drive(4'b0000, 1'b1);
        chk("wrap1_pulse", 32'(wrap), 1);
        chk("wrap1_cnt",   32'(wrap_count), 1);
        for (int k = 1; k < 8; k++) drive(jtab[k], 1'b1);
        drive(4'b0000, 1'b1);
        chk("wrap2_cnt", 32'(wrap_count), 2);
        for (int k = 1; k < 6; k++) drive(jtab[k], 1'b1);

        // Reset mid-lock at phase 5, between edges
        #2;
        Clr = 1'b0;
        #1;
        chk_zero("midrst");
        model_reset();
        #1;
        Clr = 1'b1;
        drive(4'b1100, 1'b1);
        chk("postrst_phase", 32'(phase), 2);
        chk("postrst_lk",    32'(locked), 0);

        // Out-of-order while locked at phase 3
        drive(4'b1000, 1'b1);
        drive(4'b1100, 1'b1);
        drive(4'b1110, 1'b1);
        drive(4'b0011, 1'b1);
        chk("ooo_se",    32'(seq_error), 1);
        chk("ooo_phase", 32'(phase), 6);
        drive(4'b0001, 1'b1);
        drive(4'b0000, 1'b1);
        chk("relock_nowrap", 32'(wrap), 0);
        chk("relock_lk",     32'(locked), 1);

        // Illegal codes
        drive(4'b1010, 1'b1);
        chk("ill_pulse", 32'(illegal_code), 1);
        drive(4'b0110, 1'b1);
        chk("ill_hunt_pv", 32'(phase_valid), 0);

        // Hold and gaps
        drive(4'b0000, 1'b1); drive(4'b1000, 1'b1); drive(4'b1100, 1'b1);
        for (int k = 0; k < 3; k++) begin
            drive(4'b1100, 1'b1);
            drive(4'b1010, 1'b0);
        end
        drive(4'b1110, 1'b1);
        chk("hold_next_phase", 32'(phase), 3);

        // Hold inside VERIFY and illegal from VERIFY
        drive(4'b1000, 1'b1); drive(4'b1000, 1'b1); drive(4'b1100, 1'b1);
        drive(4'b1011, 1'b1);

        // Wrap counter rollover
        drive(4'b0000, 1'b1); drive(4'b1000, 1'b1); drive(4'b1100, 1'b1);
        for (int w = 0; w < 257; w++) begin
            for (int k = 3; k < 8; k++) drive(jtab[k], 1'b1);
            for (int k = 0; k < 3; k++) drive(jtab[k], 1'b1);
        end

        // Random mix biased toward in-order codes
        for (int n = 0; n < 400; n++) begin
            if ($urandom_range(0, 1) == 0) rc = jtab[(m_ph + 1) % 8];
            else rc = 4'($urandom_range(0, 15));
            drive(rc, $urandom_range(0, 3) != 0);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
